// File: rtl/lap_stopwatch.sv
// lap_stopwatch: 4-digit BCD stopwatch (M:DS.d) with count-up/count-down
// modes, countdown preload, lap freeze, clear and a terminal "done" pulse.
// Control inputs are single-cycle pulses. Priority is clear > start_stop > lap.
// Every output is registered and loaded from the next-state values, so it
// changes together with the internal state.
module lap_stopwatch #(
  parameter logic [31:0] TICK_DIV = 32'd10_000_000,
  parameter logic [3:0]  MAX_MIN  = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic       mode,
  input  logic [3:0] load_minutes,
  input  logic [3:0] load_dekaseconds,
  input  logic [3:0] load_seconds,
  input  logic [3:0] load_deciseconds,
  output logic [3:0] minutes,
  output logic [3:0] dekaseconds,
  output logic [3:0] seconds,
  output logic [3:0] deciseconds,
  output logic       running,
  output logic       lap_active,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;
  typedef struct packed {
    logic [3:0] m;
    logic [3:0] dk;
    logic [3:0] s;
    logic [3:0] ds;
  } bcd_t;

  localparam bcd_t UP_TERM = {MAX_MIN, 4'd5, 4'd9, 4'd9};

  state_t      r_state;
  bcd_t        r_live;
  bcd_t        r_lap;
  logic        r_mode;
  logic        r_lap_active;
  logic [31:0] r_cnt;

  state_t      w_nstate;
  bcd_t        w_nlive;
  bcd_t        w_nlap;
  bcd_t        w_step;
  bcd_t        w_pre;
  logic        w_nmode;
  logic        w_nlap_active;
  logic        w_ndone;
  logic        w_tick;
  logic [31:0] w_ncnt;

  // One 0.1 s step with BCD carry (up) or borrow (down); wraps at the limits.
  function automatic bcd_t f_step(input bcd_t c, input logic dn);
    bcd_t n;
    n = c;
    if (!dn) begin
      if (c.ds != 4'd9) n.ds = c.ds + 4'd1;
      else begin
        n.ds = 4'd0;
        if (c.s != 4'd9) n.s = c.s + 4'd1;
        else begin
          n.s = 4'd0;
          if (c.dk != 4'd5) n.dk = c.dk + 4'd1;
          else begin
            n.dk = 4'd0;
            n.m  = (c.m != MAX_MIN) ? c.m + 4'd1 : 4'd0;
          end
        end
      end
    end else begin
      if (c.ds != 4'd0) n.ds = c.ds - 4'd1;
      else begin
        n.ds = 4'd9;
        if (c.s != 4'd0) n.s = c.s - 4'd1;
        else begin
          n.s = 4'd9;
          if (c.dk != 4'd0) n.dk = c.dk - 4'd1;
          else begin
            n.dk = 4'd5;
            n.m  = (c.m != 4'd0) ? c.m - 4'd1 : MAX_MIN;
          end
        end
      end
    end
    return n;
  endfunction

  // Terminal value: 0:00.0 counting down, MAX_MIN:59.9 counting up.
  function automatic logic f_term(input bcd_t c, input logic dn);
    return dn ? (c == '0) : (c == UP_TERM);
  endfunction

  // Clamped countdown preload and the step candidate for this cycle.
  always_comb begin
    w_pre.m  = (load_minutes     > MAX_MIN) ? MAX_MIN : load_minutes;
    w_pre.dk = (load_dekaseconds > 4'd5)    ? 4'd5    : load_dekaseconds;
    w_pre.s  = (load_seconds     > 4'd9)    ? 4'd9    : load_seconds;
    w_pre.ds = (load_deciseconds > 4'd9)    ? 4'd9    : load_deciseconds;
    w_tick   = (r_state == S_RUN) && (r_cnt == TICK_DIV - 32'd1);
    w_step   = f_step(r_live, r_mode);
  end

  // Next-state decode: tick divider, control pulses, count step and lap.
  always_comb begin
    w_nstate      = r_state;
    w_nlive       = r_live;
    w_nlap        = r_lap;
    w_nlap_active = r_lap_active;
    w_nmode       = (r_state == S_IDLE) ? mode : r_mode;
    w_ndone       = 1'b0;
    case (r_state)
      S_RUN:   w_ncnt = w_tick ? 32'd0 : r_cnt + 32'd1;
      S_PAUSE: w_ncnt = r_cnt;
      default: w_ncnt = 32'd0;
    endcase

    if (clear) begin
      // Clear wins over everything, including a tick on the same edge.
      w_nstate      = S_IDLE;
      w_nlap_active = 1'b0;
      w_ncnt        = 32'd0;
      w_nlive       = mode ? w_pre : '0;
    end else begin
      if (w_tick) begin
        w_nlive = w_step;
        if (f_term(w_step, r_mode)) begin
          w_nstate = S_DONE;
          w_ndone  = 1'b1;
          w_ncnt   = 32'd0;
        end
      end
      if (start_stop) begin
        case (r_state)
          S_IDLE:
            if (f_term(r_live, mode)) begin
              w_nstate = S_DONE;
              w_ndone  = 1'b1;
            end else begin
              w_nstate = S_RUN;
            end
          // A terminal step on this edge still ends the run in DONE.
          S_RUN:   if (!w_ndone) w_nstate = S_PAUSE;
          S_PAUSE: w_nstate = S_RUN;
          default: ;
        endcase
      end else if (lap) begin
        if (r_lap_active && r_state != S_IDLE) begin
          w_nlap_active = 1'b0;
        end else if (!r_lap_active && r_state == S_RUN) begin
          w_nlap_active = 1'b1;
          w_nlap        = r_live;
        end
      end
    end
  end

  // State and registered outputs; outputs track the next-state values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_live       <= '0;
      r_lap        <= '0;
      r_mode       <= 1'b0;
      r_lap_active <= 1'b0;
      r_cnt        <= 32'd0;
      minutes      <= 4'd0;
      dekaseconds  <= 4'd0;
      seconds      <= 4'd0;
      deciseconds  <= 4'd0;
      running      <= 1'b0;
      lap_active   <= 1'b0;
      done         <= 1'b0;
    end else begin
      r_state      <= w_nstate;
      r_live       <= w_nlive;
      r_lap        <= w_nlap;
      r_mode       <= w_nmode;
      r_lap_active <= w_nlap_active;
      r_cnt        <= w_ncnt;
      {minutes, dekaseconds, seconds, deciseconds} <= w_nlap_active ? w_nlap : w_nlive;
      running      <= (w_nstate == S_RUN);
      lap_active   <= w_nlap_active;
      done         <= w_ndone;
    end
  end

endmodule

// File: doc/lap_stopwatch.md
Name: lap_stopwatch

Overview:
Parametrised successor to the team's 4-digit stopwatch core. Adds count-up/count-down modes, a preloadable start value for countdown, a lap (display-freeze) function, an explicit clear, and a terminal "done" event. It has an internal tick divider. Its BCD outputs feed the existing SegDisplay/NumToSeg path unchanged. Its control inputs come from the existing OnePulse/Debounce chain as single-cycle pulses.

Parameters:
- TICK_DIV, 32'd10_000_000: clk cycles per count tick. The default gives 0.1 s at 100 MHz. Legal range is >= 2.
- MAX_MIN, 4'd9: maximum value of the minutes digit. Legal range is 1..9.

Ports:
- clk, input, 1: system clock. All logic is on posedge clk.
- rst, input, 1: synchronous, active-low reset. It acts when rst==0 at a posedge clk.
- start_stop, input, 1: single-cycle pulse that toggles run/pause.
- lap, input, 1: single-cycle pulse that toggles lap freeze.
- clear, input, 1: single-cycle pulse that returns to IDLE and reloads the count.
- mode, input, 1: 0 selects count-up, 1 selects count-down. Sampled only in IDLE.
- load_minutes / load_dekaseconds / load_seconds / load_deciseconds, input, 4 each: countdown preload in BCD.
- minutes / dekaseconds / seconds / deciseconds, output, 4 each: displayed BCD value (live or lap-frozen).
- running, output, 1: high while in state RUN.
- lap_active, output, 1: high while the display is frozen.
- done, output, 1: one-cycle pulse on reaching the terminal value.

Behaviour:
- Reset (rst==0) sets:
  - state to IDLE
  - count to 0:00.0
  - lap register to 0
  - latched mode to 0
  - tick counter to 0
  - all outputs to 0
- State machine has four states: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Input priority within a cycle: clear > start_stop > lap.
- clear, from any state:
  - next state is IDLE and lap_active is 0.
  - The tick counter resets to 0.
  - The count loads 0:00.0 if mode==0.
  - If mode==1, the count loads the preload, clamped per digit: minutes to MAX_MIN, dekaseconds to 5, seconds and deciseconds to 9.
- Latched mode is updated from `mode` every cycle while in IDLE. It is frozen in all other states.
- start_stop transitions:
  - In IDLE: latch mode, then go to RUN. Exception: if the count is already terminal, go to DONE and pulse done on the next cycle. Terminal is 0:00.0 for down, MAX_MIN:59.9 for up.
  - In RUN: go to PAUSE.
  - In PAUSE: go to RUN.
  - In DONE: ignored.
- Tick counter:
  - Counts 0..TICK_DIV-1 only in RUN and wraps to 0.
  - Holds its value in PAUSE; resumes without restart.
  - Is 0 in IDLE and DONE.
  - tick = RUN && cnt==TICK_DIV-1.
  - The first tick after a start from IDLE occurs on the TICK_DIV-th RUN cycle.
- On tick, the count steps by 0.1 s with BCD cascade rules:
  - deciseconds and seconds: 0..9.
  - dekaseconds: 0..5.
  - minutes: 0..MAX_MIN.
  - Up mode carries; down mode borrows (for example, 1:00.0 becomes 0:59.9).
- Terminal event:
  - When a tick produces the terminal value, the count saturates at it (no wrap) and state goes to DONE.
  - done is 1 for exactly the cycle following that tick edge, coincident with the first cycle the new count is visible.
  - running drops in the same cycle.
- Tick coinciding with start_stop in RUN: the step is applied and the state goes to PAUSE.
- Tick coinciding with clear: clear wins and the step is discarded.
- Lap:
  - In RUN with lap_active==0: copy the live count into the lap register and set lap_active=1. The outputs then show the lap register while the live count keeps advancing.
  - lap with lap_active==1, in RUN, PAUSE or DONE: clear lap_active. Outputs show the live count from the next cycle.
  - lap with lap_active==0 in IDLE, PAUSE or DONE: ignored.
- Entering DONE does not clear lap_active. The frozen value stays on display until lap or clear.
- The outputs update one cycle after the causing edge: live count or lap register selected by lap_active, registered.
- Reset mid-run behaves exactly as power-on reset. No partial state is retained.

Test Plan:
1. TICK_DIV=4, MAX_MIN=9, mode=0: release reset, pulse start_stop, run 40 cycles. Expect 0:01.0, running=1, first increment visible 4 cycles after start.
2. Up-count terminal: MAX_MIN=1, TICK_DIV=2, run to 1:59.9. Expect a single done pulse, saturation at 1:59.9, running=0, state DONE. Further start_stop is ignored; clear gives 0:00.0.
3. Countdown: mode=1, preload 0:01.2, clear, start_stop. After 12 ticks expect 0:00.0 with done pulsed once. Preload 0:7F.C after clear expects 0:59.9 (clamp check).
4. Borrow: preload 1:00.0 down, one tick. Expect 0:59.9.
5. Lap: run to 0:00.5 and pulse lap. Outputs hold 0:00.5 while running continues. Pause at 0:01.0, then lap. Expect 0:01.0 and lap_active=0.
6. Collisions:
   - clear and start_stop in the same cycle: IDLE with zero count.
   - tick and start_stop in the same cycle: count stepped, PAUSE.
   - rst=0 mid-run: all outputs 0 on the next cycle.
